// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory port arbiter: FSM states, port owner and
// the request bundle used on both the requester side and the memory side.
package dmem_arb_pkg;

  localparam int unsigned DMEM_ADDR_W = 9;
  localparam int unsigned DMEM_DATA_W = 32;

  typedef enum logic [0:0] {
    S_NORMAL = 1'b0,
    S_FORCE  = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_EXT  = 2'd2
  } owner_e;

  typedef struct packed {
    logic                   rd;
    logic                   wr;
    logic [DMEM_ADDR_W-1:0] addr;
    logic [DMEM_DATA_W-1:0] wdata;
    logic [2:0]             func3;
  } dmem_req_t;

  // Keeps addr/wdata/func3 of a request but removes its enables.
  function automatic dmem_req_t req_quiet(input dmem_req_t r);
    dmem_req_t q;
    q    = r;
    q.rd = 1'b0;
    q.wr = 1'b0;
    return q;
  endfunction

endpackage

// File: rtl/dmem_port_arbiter_chk.sv
// Elaboration-time parameter checks for dmem_port_arbiter.
module dmem_port_arbiter_chk
  import dmem_arb_pkg::*;
#(
  parameter int unsigned MAX_WAIT   = 8,
  parameter int unsigned DM_ADDRESS = 9,
  parameter int unsigned DATA_W     = 32
) ();

  if (MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_bad_max_wait
    $error("dmem_port_arbiter: MAX_WAIT must be in 1..255");
  end
  if (DM_ADDRESS != DMEM_ADDR_W || DATA_W != DMEM_DATA_W) begin : g_bad_width
    $error("dmem_port_arbiter: widths must match dmem_arb_pkg");
  end

endmodule

// File: rtl/dmem_port_arbiter_starve_counter.sv
// Saturating blocked-cycle counter; sat_next flags the edge at which the
// count reaches MAX so the arbiter can switch to a forced grant.
module starve_counter #(
  parameter int unsigned MAX = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic sat_next
);

  localparam logic [7:0] MAX_C = 8'(MAX);

  logic [7:0] count_r;

  assign sat_next = inc & ~clr & (count_r >= (MAX_C - 8'd1));

  // Blocked-cycle count, cleared whenever the requester is served or leaves.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r <= 8'd0;
    end else if (clr) begin
      count_r <= 8'd0;
    end else if (inc && (count_r != MAX_C)) begin
      count_r <= count_r + 8'd1;
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the data-memory port between the MEM stage (fixed priority) and an
// external requester, with a starvation-forced external grant.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned DM_ADDRESS = 9,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MAX_WAIT   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  core_rd,
  input  logic                  core_wr,
  input  logic [DM_ADDRESS-1:0] core_addr,
  input  logic [DATA_W-1:0]     core_wdata,
  input  logic [2:0]            core_func3,
  output logic [DATA_W-1:0]     core_rdata,
  output logic                  core_stall,
  input  logic                  ext_valid,
  input  logic                  ext_we,
  input  logic [DM_ADDRESS-1:0] ext_addr,
  input  logic [DATA_W-1:0]     ext_wdata,
  input  logic [2:0]            ext_func3,
  output logic                  ext_ready,
  output logic                  ext_rvalid,
  output logic [DATA_W-1:0]     ext_rdata,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [2:0]            mem_func3,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  err_conflict
);

  dmem_port_arbiter_chk #(
    .MAX_WAIT   (MAX_WAIT),
    .DM_ADDRESS (DM_ADDRESS),
    .DATA_W     (DATA_W)
  ) u_chk ();

  state_e            state_r, state_next_s;
  owner_e            owner_s;
  dmem_req_t         core_req_s, ext_req_s, mem_req_s;
  logic              core_any_s, ext_hs_s, blocked_s, cnt_clr_s, sat_next_s;
  logic              ext_rvalid_r, err_conflict_r;
  logic [DATA_W-1:0] ext_rdata_r;

  // A simultaneous read+write from the core is treated as a write.
  assign core_any_s = core_rd | core_wr;
  assign core_req_s = '{rd: core_rd & ~core_wr, wr: core_wr, addr: core_addr,
                        wdata: core_wdata, func3: core_func3};
  assign ext_req_s  = '{rd: ~ext_we, wr: ext_we, addr: ext_addr,
                        wdata: ext_wdata, func3: ext_func3};

  // Port owner selection: forced ext, then core, then ext.
  always_comb begin
    owner_s = OWN_NONE;
    if ((state_r == S_FORCE) && ext_valid) begin
      owner_s = OWN_EXT;
    end else if (core_any_s) begin
      owner_s = OWN_CORE;
    end else if (ext_valid) begin
      owner_s = OWN_EXT;
    end else begin
      owner_s = OWN_NONE;
    end
  end

  // Memory-side mux; an idle port still presents the core address/data.
  always_comb begin
    mem_req_s = req_quiet(core_req_s);
    case (owner_s)
      OWN_CORE: mem_req_s = core_req_s;
      OWN_EXT:  mem_req_s = ext_req_s;
      OWN_NONE: mem_req_s = req_quiet(core_req_s);
      default:  mem_req_s = req_quiet(core_req_s);
    endcase
  end

  assign mem_rd     = mem_req_s.rd & reset;
  assign mem_wr     = mem_req_s.wr & reset;
  assign mem_addr   = mem_req_s.addr;
  assign mem_wdata  = mem_req_s.wdata;
  assign mem_func3  = mem_req_s.func3;
  assign core_rdata = mem_rdata;
  assign ext_ready  = (owner_s == OWN_EXT) & reset;
  assign core_stall = (owner_s == OWN_EXT) & core_any_s & reset;

  assign ext_hs_s   = ext_valid & ext_ready;
  assign blocked_s  = ext_valid & ~ext_ready;
  assign cnt_clr_s  = ext_hs_s | ~ext_valid;

  starve_counter #(.MAX(MAX_WAIT)) u_starve (
    .clk      (clk),
    .reset    (reset),
    .inc      (blocked_s),
    .clr      (cnt_clr_s),
    .sat_next (sat_next_s)
  );

  // Force state lasts until the one forced ext access completes or is withdrawn.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_NORMAL: begin
        if (sat_next_s) state_next_s = S_FORCE;
        else            state_next_s = S_NORMAL;
      end
      S_FORCE: begin
        if (cnt_clr_s) state_next_s = S_NORMAL;
        else           state_next_s = S_FORCE;
      end
      default: state_next_s = S_NORMAL;
    endcase
  end

  // FSM, external read response and sticky conflict flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r        <= S_NORMAL;
      ext_rvalid_r   <= 1'b0;
      ext_rdata_r    <= '0;
      err_conflict_r <= 1'b0;
    end else begin
      state_r        <= state_next_s;
      ext_rvalid_r   <= ext_hs_s & ~ext_we;
      ext_rdata_r    <= (ext_hs_s & ~ext_we) ? mem_rdata : ext_rdata_r;
      err_conflict_r <= err_conflict_r | (core_rd & core_wr);
    end
  end

  assign ext_rvalid   = ext_rvalid_r;
  assign ext_rdata    = ext_rdata_r;
  assign err_conflict = err_conflict_r;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter with a word-wide memory model.
module tb_dmem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        core_rd, core_wr;
  logic [8:0]  core_addr;
  logic [31:0] core_wdata;
  logic [2:0]  core_func3;
  logic [31:0] core_rdata;
  logic        core_stall;
  logic        ext_valid, ext_we;
  logic [8:0]  ext_addr;
  logic [31:0] ext_wdata;
  logic [2:0]  ext_func3;
  logic        ext_ready, ext_rvalid;
  logic [31:0] ext_rdata;
  logic        mem_rd, mem_wr;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_func3;
  logic [31:0] mem_rdata;
  logic        err_conflict;

  logic [31:0] mem_model [0:127];
  logic [31:0] exp_q [$];
  int          n_cmp = 0;
  int          n_bad = 0;

  dmem_port_arbiter #(.DM_ADDRESS(9), .DATA_W(32), .MAX_WAIT(8)) dut (
    .clk(clk), .reset(reset),
    .core_rd(core_rd), .core_wr(core_wr), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_func3(core_func3),
    .core_rdata(core_rdata), .core_stall(core_stall),
    .ext_valid(ext_valid), .ext_we(ext_we), .ext_addr(ext_addr),
    .ext_wdata(ext_wdata), .ext_func3(ext_func3),
    .ext_ready(ext_ready), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_func3(mem_func3), .mem_rdata(mem_rdata),
    .err_conflict(err_conflict)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem_model[mem_addr[8:2]];

  always @(posedge clk) begin
    if (mem_wr) mem_model[mem_addr[8:2]] <= mem_wdata;
  end

  // Response scoreboard: every rvalid pulse must match the oldest expected word.
  always @(negedge clk) begin
    logic [31:0] e;
    if (reset === 1'b1 && ext_rvalid === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL rsp_unexpected: rvalid with rdata=%h, expected no response", ext_rdata);
      end else begin
        e = exp_q.pop_front();
        if (ext_rdata !== e) begin
          n_bad++;
          $display("FAIL rsp_data: got %h expected %h", ext_rdata, e);
        end
      end
    end
  end

  // Ext request must stay stable while it is waiting.
  logic        held_r = 1'b0;
  logic [44:0] held_req_r;
  always @(posedge clk) begin
    if (reset === 1'b1 && held_r && ext_valid) begin
      n_cmp++;
      if ({ext_we, ext_addr, ext_wdata, ext_func3} !== held_req_r) begin
        n_bad++;
        $display("FAIL ext_stable: got %h expected %h",
                 {ext_we, ext_addr, ext_wdata, ext_func3}, held_req_r);
      end
    end
    held_r     <= (reset === 1'b1) && ext_valid && !ext_ready;
    held_req_r <= {ext_we, ext_addr, ext_wdata, ext_func3};
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, limit 200000 expected");
    $fatal(1);
  end

  task automatic drive_idle();
    core_rd = 1'b0; core_wr = 1'b0; core_addr = 9'h100;
    core_wdata = 32'h0; core_func3 = 3'b010;
    ext_valid = 1'b0; ext_we = 1'b0; ext_addr = 9'h000;
    ext_wdata = 32'h0; ext_func3 = 3'b010;
  endtask

  task automatic ext_read(input logic [8:0] a, input logic [31:0] expv);
    ext_valid = 1'b1; ext_we = 1'b0; ext_addr = a;
    exp_q.push_back(expv);
  endtask

  task automatic test_reset();
    drive_idle();
    reset = 1'b0;
    ext_valid = 1'b1; core_wr = 1'b1;
    @(negedge clk); #1;
    n_cmp++; if (ext_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready: got %b expected 0", ext_ready); end
    n_cmp++; if (mem_wr !== 1'b0) begin n_bad++; $display("FAIL rst_mem_wr: got %b expected 0", mem_wr); end
    n_cmp++; if (core_stall !== 1'b0) begin n_bad++; $display("FAIL rst_stall: got %b expected 0", core_stall); end
    n_cmp++; if ({ext_rvalid, ext_rdata, err_conflict} !== 34'h0) begin n_bad++; $display("FAIL rst_regs: got %h expected 0", {ext_rvalid, ext_rdata, err_conflict}); end
    @(negedge clk);
    reset = 1'b1; drive_idle();
    @(negedge clk);
    ext_valid = 1'b1; ext_we = 1'b0; ext_addr = 9'h010;
    @(posedge clk); #2;
    n_cmp++; if (ext_rvalid !== 1'b1) begin n_bad++; $display("FAIL rst_pre_rvalid: got %b expected 1", ext_rvalid); end
    ext_we = 1'b1; ext_addr = 9'h040; ext_wdata = 32'h0BAD0BAD;
    reset = 1'b0; #1;
    n_cmp++; if (ext_rvalid !== 1'b0) begin n_bad++; $display("FAIL rst_mid_rvalid: got %b expected 0", ext_rvalid); end
    n_cmp++; if (ext_ready !== 1'b0) begin n_bad++; $display("FAIL rst_mid_ready: got %b expected 0", ext_ready); end
    n_cmp++; if (mem_wr !== 1'b0) begin n_bad++; $display("FAIL rst_mid_mem_wr: got %b expected 0", mem_wr); end
    @(negedge clk);
    reset = 1'b1; drive_idle();
    ext_read(9'h010, 32'hDEADBEEF); #1;
    n_cmp++; if (ext_ready !== 1'b1) begin n_bad++; $display("FAIL rst_first_grant: got %b expected 1", ext_ready); end
    @(negedge clk); drive_idle();
    @(negedge clk);
  endtask

  task automatic test_ext_read();
    @(negedge clk);
    ext_read(9'h010, 32'hDEADBEEF); ext_func3 = 3'b100; #1;
    n_cmp++; if (ext_ready !== 1'b1) begin n_bad++; $display("FAIL rd_ready: got %b expected 1", ext_ready); end
    n_cmp++; if ({mem_rd, mem_wr, mem_addr, mem_func3} !== {1'b1, 1'b0, 9'h010, 3'b100}) begin n_bad++; $display("FAIL rd_mem: got %h expected %h", {mem_rd, mem_wr, mem_addr, mem_func3}, {1'b1, 1'b0, 9'h010, 3'b100}); end
    @(negedge clk); drive_idle(); #1;
    n_cmp++; if (ext_rvalid !== 1'b1) begin n_bad++; $display("FAIL rd_rvalid: got %b expected 1", ext_rvalid); end
    @(negedge clk); #1;
    n_cmp++; if (ext_rvalid !== 1'b0) begin n_bad++; $display("FAIL rd_pulse: got %b expected 0", ext_rvalid); end
  endtask

  task automatic test_starvation();
    @(negedge clk);
    core_rd = 1'b1; core_addr = 9'h100;
    ext_read(9'h010, 32'hDEADBEEF);
    for (int i = 0; i < 8; i++) begin
      #1;
      n_cmp++; if ({ext_ready, core_stall, mem_addr} !== {1'b0, 1'b0, 9'h100}) begin n_bad++; $display("FAIL starve_block%0d: got %h expected %h", i, {ext_ready, core_stall, mem_addr}, {1'b0, 1'b0, 9'h100}); end
      @(negedge clk);
    end
    #1;
    n_cmp++; if ({ext_ready, core_stall, mem_rd, mem_addr} !== {1'b1, 1'b1, 1'b1, 9'h010}) begin n_bad++; $display("FAIL starve_force: got %h expected %h", {ext_ready, core_stall, mem_rd, mem_addr}, {1'b1, 1'b1, 1'b1, 9'h010}); end
    @(negedge clk);
    ext_valid = 1'b0; #1;
    n_cmp++; if ({core_stall, mem_addr} !== {1'b0, 9'h100}) begin n_bad++; $display("FAIL starve_after: got %h expected %h", {core_stall, mem_addr}, {1'b0, 9'h100}); end
    n_cmp++; if (dut.u_starve.count_r !== 8'd0) begin n_bad++; $display("FAIL starve_cnt: got %0d expected 0", dut.u_starve.count_r); end
    @(negedge clk); drive_idle();
  endtask

  task automatic test_same_cycle();
    @(negedge clk);
    core_wr = 1'b1; core_addr = 9'h020; core_wdata = 32'h12345678;
    ext_read(9'h020, 32'h12345678); #1;
    n_cmp++; if ({ext_ready, core_stall, mem_wr, mem_wdata} !== {1'b0, 1'b0, 1'b1, 32'h12345678}) begin n_bad++; $display("FAIL same_core: got %h expected %h", {ext_ready, core_stall, mem_wr, mem_wdata}, {1'b0, 1'b0, 1'b1, 32'h12345678}); end
    @(negedge clk);
    core_wr = 1'b0; #1;
    n_cmp++; if ({ext_ready, mem_rd} !== 2'b11) begin n_bad++; $display("FAIL same_ext: got %b expected 11", {ext_ready, mem_rd}); end
    @(negedge clk); drive_idle();
    @(negedge clk);
  endtask

  task automatic test_conflict();
    @(negedge clk);
    core_rd = 1'b1; core_wr = 1'b1; core_addr = 9'h004; core_wdata = 32'hA5A5A5A5; #1;
    n_cmp++; if ({mem_wr, mem_rd, mem_addr} !== {1'b1, 1'b0, 9'h004}) begin n_bad++; $display("FAIL conf_mem: got %h expected %h", {mem_wr, mem_rd, mem_addr}, {1'b1, 1'b0, 9'h004}); end
    @(negedge clk); drive_idle(); #1;
    n_cmp++; if (err_conflict !== 1'b1) begin n_bad++; $display("FAIL conf_set: got %b expected 1", err_conflict); end
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if (err_conflict !== 1'b1) begin n_bad++; $display("FAIL conf_sticky: got %b expected 1", err_conflict); end
  endtask

  task automatic test_restart();
    @(negedge clk);
    core_rd = 1'b1; core_addr = 9'h100;
    ext_read(9'h004, 32'hA5A5A5A5);
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++; if (ext_ready !== 1'b0) begin n_bad++; $display("FAIL restart_pre%0d: got %b expected 0", i, ext_ready); end
      @(negedge clk);
    end
    ext_valid = 1'b0;
    @(negedge clk);
    ext_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      n_cmp++; if (ext_ready !== 1'b0) begin n_bad++; $display("FAIL restart_block%0d: got %b expected 0", i, ext_ready); end
      @(negedge clk);
    end
    #1;
    n_cmp++; if ({ext_ready, core_stall} !== 2'b11) begin n_bad++; $display("FAIL restart_force: got %b expected 11", {ext_ready, core_stall}); end
    @(negedge clk); drive_idle();
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    ext_read(9'h010, 32'hDEADBEEF); #1;
    n_cmp++; if (ext_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_r0: got %b expected 1", ext_ready); end
    @(negedge clk);
    ext_read(9'h020, 32'h12345678); #1;
    n_cmp++; if ({ext_ready, ext_rvalid} !== 2'b11) begin n_bad++; $display("FAIL b2b_r1: got %b expected 11", {ext_ready, ext_rvalid}); end
    @(negedge clk);
    ext_we = 1'b1; ext_addr = 9'h030; ext_wdata = 32'hCAFEF00D; #1;
    n_cmp++; if ({ext_ready, mem_wr, ext_rvalid} !== 3'b111) begin n_bad++; $display("FAIL b2b_w: got %b expected 111", {ext_ready, mem_wr, ext_rvalid}); end
    @(negedge clk);
    ext_read(9'h030, 32'hCAFEF00D); #1;
    n_cmp++; if ({ext_ready, ext_rvalid} !== 2'b10) begin n_bad++; $display("FAIL b2b_r2: got %b expected 10", {ext_ready, ext_rvalid}); end
    @(negedge clk); drive_idle(); #1;
    n_cmp++; if (ext_rvalid !== 1'b1) begin n_bad++; $display("FAIL b2b_last: got %b expected 1", ext_rvalid); end
    n_cmp++; if (err_conflict !== 1'b1) begin n_bad++; $display("FAIL b2b_sticky: got %b expected 1", err_conflict); end
    @(negedge clk);
  endtask

  task automatic test_final_reset();
    reset = 1'b0; #1;
    n_cmp++; if ({err_conflict, ext_rvalid} !== 2'b00) begin n_bad++; $display("FAIL final_rst: got %b expected 00", {err_conflict, ext_rvalid}); end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL rsp_missing: got %0d pending expected 0", exp_q.size()); end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem_model[i] = 32'h0;
    mem_model[9'h010 >> 2] = 32'hDEADBEEF;
    test_reset();
    test_ext_read();
    test_starvation();
    test_same_cycle();
    test_conflict();
    test_restart();
    test_back_to_back();
    test_final_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single data-memory port between the pipeline MEM stage (core) and an external requester (program loader / debug host).
- Sits between the EX/MEM pipeline register outputs and datamemory.
- The core has fixed priority. A starvation counter forces one external grant after MAX_WAIT blocked cycles; during that cycle the core is stalled.
- External reads return registered data one cycle after the handshake.

Parameters:
DM_ADDRESS, 9, data-memory byte address width
DATA_W, 32, data width
MAX_WAIT, 8, consecutive blocked ext cycles before a forced ext grant (legal range 1..255)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
core_rd  in  1  MEM-stage read enable
core_wr  in  1  MEM-stage write enable
core_addr  in  DM_ADDRESS  MEM-stage address
core_wdata  in  DATA_W  MEM-stage store data
core_func3  in  3  MEM-stage access size/sign
core_rdata  out  DATA_W  read data to MEM/WB (combinational from mem_rdata)
core_stall  out  1  core access not serviced this cycle; hazard logic freezes PC, IF/ID, ID/EX, EX/MEM
ext_valid  in  1  external request valid
ext_we  in  1  1 = write, 0 = read
ext_addr  in  DM_ADDRESS  external address
ext_wdata  in  DATA_W  external write data
ext_func3  in  3  external access size/sign
ext_ready  out  1  external request accepted this cycle
ext_rvalid  out  1  one-cycle pulse, ext_rdata valid
ext_rdata  out  DATA_W  registered external read data
mem_rd  out  1  to datamemory read enable
mem_wr  out  1  to datamemory write enable
mem_addr  out  DM_ADDRESS  to datamemory
mem_wdata  out  DATA_W  to datamemory
mem_func3  out  3  to datamemory
mem_rdata  in  DATA_W  from datamemory, combinational read
err_conflict  out  1  sticky: core_rd and core_wr seen high together

Behaviour:
- Reset (reset=0, async) drives the following: state=S_NORMAL, wait_cnt=0, ext_rvalid=0, ext_rdata=0, err_conflict=0. While reset is low, ext_ready, core_stall, mem_rd and mem_wr are forced to 0.
- core_req = core_rd | core_wr. If both are high: treat as a write (mem_rd=0) and set err_conflict.
- Grant, combinational:
  - In S_FORCE with ext_valid: grant ext, core_stall = core_req.
  - Else if core_req: grant core, core_stall = 0.
  - Else if ext_valid: grant ext.
  - Else: no grant, mem_rd = mem_wr = 0.
- ext_ready = (grant == ext). The ext handshake is ext_valid & ext_ready.
- Mem mux: the owner's addr/wdata/func3 drive the mem_* outputs. With no owner, addr/wdata/func3 hold the core values.
- wait_cnt (8-bit, saturating at MAX_WAIT):
  - +1 when ext_valid & !ext_ready.
  - Cleared on ext handshake or when ext_valid=0.
- FSM:
  - S_NORMAL -> S_FORCE at the edge where wait_cnt reaches MAX_WAIT.
  - S_FORCE -> S_NORMAL on ext handshake or ext_valid=0.
  - Each S_FORCE cycle therefore grants exactly one ext access.
- Read response: on an ext read handshake, ext_rdata <= mem_rdata at that edge and ext_rvalid=1 for the next cycle only. There is no backpressure on the response.
- Back-to-back ext reads with the core idle give one handshake per cycle, with ext_rvalid high on consecutive cycles.
- Core latency is unchanged (0 extra cycles) whenever core_stall=0. A core access is never dropped: a stalled access is retried by the frozen pipeline the next cycle.
- Ext request signals must remain stable while ext_valid=1 and ext_ready=0. This is a bench assertion, not a design check.
- Reset mid-response: a pending ext_rvalid is cancelled and the response is lost. The external side must reissue.
- MAX_WAIT must be ≥ 1; this is checked with an elaboration assertion.

Decomposition:
- Package dmem_arb_pkg holds:
  - state enum {S_NORMAL, S_FORCE}
  - owner enum {OWN_NONE, OWN_CORE, OWN_EXT}
  - struct dmem_req_t {rd, wr, addr, wdata, func3}, used for both request inputs and the mem-side bundle
- Sub-module starve_counter (saturating counter with clear and sat flag, parameter MAX).
- The arbiter top holds the FSM, the mux and the response register.

Test Plan:
1. Reset low mid-traffic with ext_valid=1 -> ext_ready=0, ext_rvalid=0, mem_wr=0 immediately (async). After release, the first ext request with the core idle is granted the same cycle.
2. Core idle; ext read addr 0x010 with memory holding 0xDEADBEEF -> ext_ready=1 in cycle N; ext_rvalid=1 and ext_rdata=0xDEADBEEF in cycle N+1 only.
3. core_rd held continuously, ext_valid=1, MAX_WAIT=8 -> ext_ready=0 for 8 cycles, 9th cycle ext_ready=1 and core_stall=1. Following cycle core_stall=0 and wait_cnt=0.
4. Core store 0x12345678 at 0x020 and ext read of 0x020 in the same cycle (not forced) -> core wins, then ext read returns 0x12345678.
5. core_rd=core_wr=1 with addr 0x004 -> mem_wr=1, mem_rd=0, err_conflict=1 and stays 1 until reset.
6. ext_valid drops after 5 blocked cycles, then rises again -> wait_cnt restarts from 0; forced grant occurs only after 8 new blocked cycles.
